// File: rtl/el2_trace_ser_pkg.sv
// Shared types for the retire-trace serializer: the core trace packet, the
// FIFO entry stored per packet, the header word layout and the FSM states.
package el2_trace_ser_pkg;

   typedef struct packed {
      logic [31:0] trace_rv_i_insn_ip;
      logic [31:0] trace_rv_i_address_ip;
      logic        trace_rv_i_valid_ip;
      logic        trace_rv_i_exception_ip;
      logic [4:0]  trace_rv_i_ecause_ip;
      logic        trace_rv_i_interrupt_ip;
      logic [31:0] trace_rv_i_tval_ip;
   } el2_trace_pkt_t;

   // The valid bit is implied by presence in the FIFO, so it is not stored.
   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] address;
      logic        exception;
      logic [4:0]  ecause;
      logic        interrupt;
      logic [31:0] tval;
   } el2_trace_entry_t;

   localparam logic [3:0] EL2_TRACE_SYNC = 4'hA;

   typedef struct packed {
      logic [3:0]  sync;
      logic        drop_sat;
      logic        exception;
      logic        interrupt;
      logic [4:0]  ecause;
      logic [3:0]  nwords;
      logic [15:0] drops;
   } el2_trace_hdr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_INSN,
      ST_ADDR,
      ST_TVAL
   } el2_trace_ser_state_t;

   function automatic el2_trace_entry_t el2_trace_strip(el2_trace_pkt_t p);
      el2_trace_entry_t e;
      e.insn      = p.trace_rv_i_insn_ip;
      e.address   = p.trace_rv_i_address_ip;
      e.exception = p.trace_rv_i_exception_ip;
      e.ecause    = p.trace_rv_i_ecause_ip;
      e.interrupt = p.trace_rv_i_interrupt_ip;
      e.tval      = p.trace_rv_i_tval_ip;
      return e;
   endfunction

   function automatic el2_trace_hdr_t el2_trace_mk_hdr(el2_trace_entry_t e, logic [15:0] snap);
      el2_trace_hdr_t h;
      h.sync      = EL2_TRACE_SYNC;
      h.drop_sat  = (snap == 16'hFFFF);
      h.exception = e.exception;
      h.interrupt = e.interrupt;
      h.ecause    = e.ecause;
      h.nwords    = (e.exception | e.interrupt) ? 4'd4 : 4'd3;
      h.drops     = snap;
      return h;
   endfunction

endpackage

// File: rtl/el2_trace_fifo.sv
// Generic synchronous FIFO with flop storage. Push is ignored when full and
// pop is ignored when empty; a same-cycle pop does not make room for a push.
module el2_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/el2_trace_ser.sv
// Retire-trace serializer: buffers trace packets and emits each as 3 or 4
// 32-bit words on a valid/ready port. Never stalls the core; overflow is counted.
//
// state | meaning
// IDLE  | FIFO empty, nothing on the port
// HDR   | header word of the FIFO head (sync, cause, length, drop snapshot)
// INSN  | instruction word
// ADDR  | PC word; last word unless the entry carries exception/interrupt
// TVAL  | trap value word, always last
module el2_trace_ser
   import el2_trace_ser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_l,
   input  logic           trace_enable,
   input  el2_trace_pkt_t trace_pkt,
   output logic           tr_valid,
   output logic [31:0]    tr_data,
   output logic           tr_last,
   input  logic           tr_ready,
   output logic           tr_busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = $bits(el2_trace_entry_t);

   el2_trace_ser_state_t state, state_nxt;

   logic [EW-1:0]    head_bits;
   el2_trace_entry_t head;
   el2_trace_hdr_t   hdr;
   logic             fifo_full;
   logic             fifo_empty;
   logic [AW:0]      fifo_count;

   logic qual, push, drop, accept, has_tval, last_word, pop, more_pkts, load;
   logic [15:0] drop_cnt;
   logic [15:0] drop_snap;

   assign qual      = trace_enable & trace_pkt.trace_rv_i_valid_ip;
   assign push      = qual & ~fifo_full;
   assign drop      = qual & fifo_full;
   assign head      = head_bits;
   assign has_tval  = head.exception | head.interrupt;
   assign accept    = tr_valid & tr_ready;
   assign last_word = ((state == ST_ADDR) && !has_tval) || (state == ST_TVAL);
   assign pop       = accept & last_word;
   // Post-pop occupancy excludes a push landing in the same cycle.
   assign more_pkts = (fifo_count > CW'(1));
   assign load      = ((state == ST_IDLE) && !fifo_empty) || (pop && more_pkts);
   assign hdr       = el2_trace_mk_hdr(head, drop_snap);
   assign tr_busy   = !fifo_empty || (state != ST_IDLE);

   el2_trace_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .push  (push),
      .din   (el2_trace_strip(trace_pkt)),
      .pop   (pop),
      .dout  (head_bits),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tr_valid  = 1'b0;
      tr_last   = 1'b0;
      tr_data   = '0;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) state_nxt = ST_HDR;
         end
         ST_HDR: begin
            tr_valid = 1'b1;
            tr_data  = hdr;
            if (tr_ready) state_nxt = ST_INSN;
         end
         ST_INSN: begin
            tr_valid = 1'b1;
            tr_data  = head.insn;
            if (tr_ready) state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            tr_valid = 1'b1;
            tr_data  = head.address;
            tr_last  = !has_tval;
            if (tr_ready) begin
               if (has_tval)       state_nxt = ST_TVAL;
               else if (more_pkts) state_nxt = ST_HDR;
               else                state_nxt = ST_IDLE;
            end
         end
         ST_TVAL: begin
            tr_valid = 1'b1;
            tr_data  = head.tval;
            tr_last  = 1'b1;
            if (tr_ready) state_nxt = more_pkts ? ST_HDR : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Snapshot excludes a drop in the load cycle; that drop seeds the new count.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         drop_cnt  <= '0;
         drop_snap <= '0;
      end else if (load) begin
         drop_snap <= drop_cnt;
         drop_cnt  <= {15'd0, drop};
      end else if (drop && (drop_cnt != 16'hFFFF)) begin
         drop_cnt  <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_el2_trace_ser.sv
// Scenario bench for el2_trace_ser: expected words are queued when packets are
// driven and compared by a monitor as the serializer hands each word over.
module tb_el2_trace_ser;
   import el2_trace_ser_pkg::*;

   logic           clk;
   logic           rst_l;
   logic           trace_enable;
   el2_trace_pkt_t trace_pkt;
   logic           tr_valid;
   logic [31:0]    tr_data;
   logic           tr_last;
   logic           tr_ready;
   logic           tr_busy;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   el2_trace_ser #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .trace_enable (trace_enable),
      .trace_pkt    (trace_pkt),
      .tr_valid     (tr_valid),
      .tr_data      (tr_data),
      .tr_last      (tr_last),
      .tr_ready     (tr_ready),
      .tr_busy      (tr_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_l && tr_valid && tr_ready) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_word unexpected data=%h last=%b want no word", tr_data, tr_last);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (tr_data !== e.data || tr_last !== e.last)
               $display("FAIL sb_word data=%h last=%b want data=%h last=%b", tr_data, tr_last, e.data, e.last);
            else
               n_pass++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   function automatic el2_trace_pkt_t mk_pkt(input logic [31:0] insn, input logic [31:0] addr,
                                             input logic exc, input logic intr,
                                             input logic [4:0] cause, input logic [31:0] tval);
      el2_trace_pkt_t p;
      p.trace_rv_i_insn_ip      = insn;
      p.trace_rv_i_address_ip   = addr;
      p.trace_rv_i_valid_ip     = 1'b1;
      p.trace_rv_i_exception_ip = exc;
      p.trace_rv_i_ecause_ip    = cause;
      p.trace_rv_i_interrupt_ip = intr;
      p.trace_rv_i_tval_ip      = tval;
      return p;
   endfunction

   task automatic exp_pkt(input el2_trace_pkt_t p, input logic [15:0] snap);
      logic        x;
      logic [31:0] h;
      x = p.trace_rv_i_exception_ip | p.trace_rv_i_interrupt_ip;
      h = {4'hA, (snap == 16'hFFFF), p.trace_rv_i_exception_ip, p.trace_rv_i_interrupt_ip,
           p.trace_rv_i_ecause_ip, (x ? 4'd4 : 4'd3), snap};
      exp_q.push_back('{h, 1'b0});
      exp_q.push_back('{p.trace_rv_i_insn_ip, 1'b0});
      exp_q.push_back('{p.trace_rv_i_address_ip, !x});
      if (x) exp_q.push_back('{p.trace_rv_i_tval_ip, 1'b1});
   endtask

   task automatic send(input el2_trace_pkt_t p);
      trace_pkt = p;
      @(posedge clk);
      #1;
      trace_pkt = '0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!tr_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++; if (tr_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", tr_valid); else n_pass++;
      n_chk++; if (tr_data !== 32'h0) $display("FAIL reset_data got=%h want=0", tr_data); else n_pass++;
      n_chk++; if (tr_last !== 1'b0) $display("FAIL reset_last got=%b want=0", tr_last); else n_pass++;
      n_chk++; if (tr_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", tr_busy); else n_pass++;
      @(posedge clk); #1;
      rst_l = 1'b1;
   endtask

   task automatic test_single();
      el2_trace_pkt_t p;
      bit ok;
      p = mk_pkt(32'h0000_0013, 32'h8000_0000, 1'b0, 1'b0, 5'd0, 32'h5555_5555);
      tr_ready = 1'b1;
      exp_pkt(p, 16'd0);
      send(p);
      @(negedge clk);
      n_chk++; if (tr_valid !== 1'b0) $display("FAIL single_n1_valid got=%b want=0", tr_valid); else n_pass++;
      @(negedge clk);
      n_chk++;
      if (tr_valid !== 1'b1 || tr_data !== 32'hA003_0000)
         $display("FAIL single_n2_hdr valid=%b data=%h want 1/a0030000", tr_valid, tr_data);
      else n_pass++;
      wait_idle(40, ok);
      n_chk++; if (!ok) $display("FAIL single_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_exception();
      el2_trace_pkt_t p;
      bit ok;
      p = mk_pkt(32'h0000_0073, 32'h8000_0100, 1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF);
      exp_pkt(p, 16'd0);
      send(p);
      repeat (2) @(negedge clk);
      n_chk++;
      if (tr_valid !== 1'b1 || tr_data !== 32'hA424_0000)
         $display("FAIL exc_hdr valid=%b data=%h want 1/a4240000", tr_valid, tr_data);
      else n_pass++;
      wait_idle(40, ok);
      n_chk++; if (!ok) $display("FAIL exc_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_stall();
      el2_trace_pkt_t p;
      bit ok;
      p = mk_pkt(32'h0000_0013, 32'h8000_0004, 1'b0, 1'b0, 5'd0, 32'h0);
      tr_ready = 1'b1;
      exp_pkt(p, 16'd0);
      send(p);
      @(posedge clk); #1;
      @(posedge clk); #1;
      tr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (tr_valid !== 1'b1 || tr_data !== 32'h0000_0013 || tr_last !== 1'b0)
            $display("FAIL stall_hold cyc=%0d valid=%b data=%h last=%b want 1/00000013/0", i, tr_valid, tr_data, tr_last);
         else n_pass++;
      end
      @(posedge clk); #1;
      tr_ready = 1'b1;
      wait_idle(40, ok);
      n_chk++; if (!ok) $display("FAIL stall_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      el2_trace_pkt_t p0, p1;
      p0 = mk_pkt(32'h0010_0093, 32'h8000_0010, 1'b0, 1'b0, 5'd0, 32'h0);
      p1 = mk_pkt(32'h0020_0113, 32'h8000_0014, 1'b0, 1'b0, 5'd0, 32'h0);
      tr_ready = 1'b0;
      exp_pkt(p0, 16'd0);
      exp_pkt(p1, 16'd0);
      send(p0);
      send(p1);
      @(posedge clk); #1;
      tr_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_chk++;
         if (tr_valid !== 1'b1) $display("FAIL b2b_valid word=%0d got=%b want=1", i, tr_valid);
         else n_pass++;
      end
      @(negedge clk);
      n_chk++;
      if (tr_busy !== 1'b0 || tr_valid !== 1'b0 || exp_q.size() != 0)
         $display("FAIL b2b_end busy=%b valid=%b pending=%0d want 0/0/0", tr_busy, tr_valid, exp_q.size());
      else n_pass++;
   endtask

   task automatic test_overflow();
      el2_trace_pkt_t p[7];
      logic [31:0] d;
      bit ok;
      tr_ready = 1'b0;
      for (int i = 0; i < 7; i++)
         p[i] = mk_pkt(32'h1000_0000 + 32'(i), 32'h9000_0000 + 32'(4 * i), 1'b0, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 7; i++) send(p[i]);
      // Head was loaded before any drop; the next packet reports the three drops.
      exp_pkt(p[0], 16'd0);
      exp_pkt(p[1], 16'd3);
      exp_pkt(p[2], 16'd0);
      exp_pkt(p[3], 16'd0);
      @(negedge clk);
      d = tr_data;
      n_chk++;
      if (tr_valid !== 1'b1 || d[31:16] !== 16'hA003 || d[15:0] !== 16'd0)
         $display("FAIL ovf_first_hdr valid=%b data=%h want 1/a0030000", tr_valid, d);
      else n_pass++;
      @(posedge clk); #1;
      tr_ready = 1'b1;
      wait_idle(80, ok);
      n_chk++; if (!ok) $display("FAIL ovf_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_enable();
      el2_trace_pkt_t p;
      bit ok;
      tr_ready     = 1'b0;
      trace_enable = 1'b0;
      send(mk_pkt(32'hBAD0_0001, 32'hBAD0_0000, 1'b0, 1'b0, 5'd0, 32'h0));
      repeat (2) @(negedge clk);
      n_chk++; if (tr_busy !== 1'b0) $display("FAIL en_ignored busy=%b want=0", tr_busy); else n_pass++;
      @(posedge clk); #1;
      trace_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         p = mk_pkt(32'h2000_0000 + 32'(i), 32'hA000_0000 + 32'(i), 1'b0, (i == 2), 5'd11, 32'hC0DE_0000 + 32'(i));
         exp_pkt(p, 16'd0);
         send(p);
      end
      trace_enable = 1'b0;
      send(mk_pkt(32'hBAD0_0002, 32'hBAD0_0004, 1'b0, 1'b0, 5'd0, 32'h0));
      send(mk_pkt(32'hBAD0_0003, 32'hBAD0_0008, 1'b0, 1'b0, 5'd0, 32'h0));
      trace_enable = 1'b1;
      tr_ready     = 1'b1;
      wait_idle(80, ok);
      n_chk++; if (!ok) $display("FAIL en_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      el2_trace_pkt_t p[6];
      el2_trace_pkt_t q;
      bit ok;
      tr_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         p[i] = mk_pkt(32'h3000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0, 5'd0, 32'h0);
      exp_pkt(p[0], 16'd0);
      for (int i = 0; i < 6; i++) send(p[i]);
      tr_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tr_ready = 1'b0;
      @(negedge clk);
      n_chk++;
      if (tr_valid !== 1'b1 || tr_last !== 1'b1 || tr_data !== 32'hB000_0000)
         $display("FAIL rstmid_addr valid=%b last=%b data=%h want 1/1/b0000000", tr_valid, tr_last, tr_data);
      else n_pass++;
      #2;
      rst_l = 1'b0;
      #1;
      n_chk++; if (tr_valid !== 1'b0) $display("FAIL rstmid_valid got=%b want=0", tr_valid); else n_pass++;
      n_chk++; if (tr_data !== 32'h0) $display("FAIL rstmid_data got=%h want=0", tr_data); else n_pass++;
      n_chk++; if (tr_busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", tr_busy); else n_pass++;
      exp_q.delete();
      @(posedge clk); #1;
      rst_l    = 1'b1;
      tr_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_chk++; if (tr_busy !== 1'b0) $display("FAIL rstmid_empty busy=%b want=0", tr_busy); else n_pass++;
      @(posedge clk); #1;
      q = mk_pkt(32'h4000_0001, 32'hC000_0000, 1'b0, 1'b0, 5'd0, 32'h0);
      exp_pkt(q, 16'd0);
      send(q);
      wait_idle(40, ok);
      n_chk++; if (!ok) $display("FAIL rstmid_drain busy=%b pending=%0d want idle", tr_busy, exp_q.size()); else n_pass++;
   endtask

   initial begin
      rst_l        = 1'b0;
      trace_enable = 1'b1;
      trace_pkt    = '0;
      tr_ready     = 1'b1;
      test_reset();
      test_single();
      test_exception();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_enable();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
